// File: rtl/video_bus_arbiter.sv
// Arbitrates one 16-bit memory bus between two display fetch channels and the CPU.
// Video channels have priority and alternate; the CPU gets a slot after a video burst.
module video_bus_arbiter #(
   parameter int ADDR_W          = 22,
   parameter int VIDEO_BURST_MAX = 4,
   parameter int TIMEOUT         = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              v0_as,
   input  logic [ADDR_W-1:0] v0_address,
   output logic              v0_ack,
   input  logic              v1_as,
   input  logic [ADDR_W-1:0] v1_address,
   output logic              v1_ack,
   input  logic              cpu_as,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [15:0]       cpu_dout,
   output logic              cpu_ack,
   output logic              cpu_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_as,
   output logic              mem_we,
   output logic [15:0]       mem_dout,
   input  logic              mem_ack,
   output logic [1:0]        grant_owner
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_V0   = 2'd1;
   localparam logic [1:0] OWN_V1   = 2'd2;
   localparam logic [1:0] OWN_CPU  = 2'd3;

   localparam logic [3:0] BURST_MAX = 4'(VIDEO_BURST_MAX);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

   state_t     r_state;
   logic       r_rr_last;   // 0: ch0 was served last, 1: ch1 was served last
   logic [3:0] r_burst;
   logic [7:0] r_tmo;

   logic       w_tmo_hit;
   logic       w_done;
   logic [1:0] w_win;

   // The counter holds the number of BUSY cycles already elapsed, so the
   // last permitted cycle is the one where it equals TIMEOUT-1.
   assign w_tmo_hit = (r_state == S_BUSY) && !mem_ack && (r_tmo == TMO_LAST);
   assign w_done    = (r_state == S_BUSY) && (mem_ack || w_tmo_hit);

   assign v0_ack  = w_done && (grant_owner == OWN_V0);
   assign v1_ack  = w_done && (grant_owner == OWN_V1);
   assign cpu_ack = (r_state == S_BUSY) && mem_ack && (grant_owner == OWN_CPU);
   assign cpu_err = w_tmo_hit && (grant_owner == OWN_CPU);

   always_comb begin
      w_win = OWN_NONE;
      if (cpu_as && (r_burst == BURST_MAX)) begin
         w_win = OWN_CPU;
      end else if (v0_as && v1_as) begin
         w_win = r_rr_last ? OWN_V0 : OWN_V1;
      end else if (v0_as) begin
         w_win = OWN_V0;
      end else if (v1_as) begin
         w_win = OWN_V1;
      end else if (cpu_as) begin
         w_win = OWN_CPU;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_rr_last   <= 1'b1;
         r_burst     <= 4'd0;
         r_tmo       <= 8'd0;
         mem_as      <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_dout    <= 16'd0;
         grant_owner <= OWN_NONE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win != OWN_NONE) begin
                  r_state     <= S_BUSY;
                  mem_as      <= 1'b1;
                  grant_owner <= w_win;
                  r_tmo       <= 8'd0;
                  case (w_win)
                     OWN_V0: begin
                        mem_address <= v0_address;
                        mem_we      <= 1'b0;
                        mem_dout    <= 16'd0;
                     end
                     OWN_V1: begin
                        mem_address <= v1_address;
                        mem_we      <= 1'b0;
                        mem_dout    <= 16'd0;
                     end
                     default: begin
                        mem_address <= cpu_address;
                        mem_we      <= cpu_we;
                        mem_dout    <= cpu_dout;
                     end
                  endcase
                  // Only video grants that keep a waiting CPU out extend the burst
                  if ((w_win == OWN_CPU) || !cpu_as) begin
                     r_burst <= 4'd0;
                  end else if (r_burst != BURST_MAX) begin
                     r_burst <= r_burst + 4'd1;
                  end
               end
            end
            S_BUSY: begin
               r_tmo <= r_tmo + 8'd1;
               if (w_done) begin
                  r_state     <= S_RELEASE;
                  mem_as      <= 1'b0;
                  mem_we      <= 1'b0;
                  grant_owner <= OWN_NONE;
                  if (grant_owner == OWN_V0) begin
                     r_rr_last <= 1'b0;
                  end else if (grant_owner == OWN_V1) begin
                     r_rr_last <= 1'b1;
                  end
               end
            end
            S_RELEASE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Randomised scoreboard bench for video_bus_arbiter: a transaction-level model predicts
// every grant and every completion pulse; a negedge monitor pops and compares them.
module tb_video_bus_arbiter;

   localparam int AW   = 22;
   localparam int BMAX = 4;
   localparam int TMO  = 255;

   logic          clk = 1'b0;
   logic          reset;
   logic          v0_as, v1_as, cpu_as, cpu_we;
   logic [AW-1:0] v0_address, v1_address, cpu_address;
   logic [15:0]   cpu_dout;
   logic          v0_ack, v1_ack, cpu_ack, cpu_err;
   logic [AW-1:0] mem_address;
   logic          mem_as, mem_we, mem_ack;
   logic [15:0]   mem_dout;
   logic [1:0]    grant_owner;

   always #5 clk = ~clk;

   video_bus_arbiter #(.ADDR_W(AW), .VIDEO_BURST_MAX(BMAX), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .v0_as(v0_as), .v0_address(v0_address), .v0_ack(v0_ack),
      .v1_as(v1_as), .v1_address(v1_address), .v1_ack(v1_ack),
      .cpu_as(cpu_as), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_dout(cpu_dout),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err),
      .mem_address(mem_address), .mem_as(mem_as), .mem_we(mem_we), .mem_dout(mem_dout),
      .mem_ack(mem_ack), .grant_owner(grant_owner)
   );

   typedef struct {
      int            cyc;
      logic [1:0]    own;
      logic [AW-1:0] addr;
      logic          we;
      logic [15:0]   dout;
   } grant_t;

   typedef struct {
      int cyc;
      int kind;   // 1 v0_ack, 2 v1_ack, 3 cpu_ack, 4 cpu_err
   } done_t;

   grant_t q_gnt[$];
   done_t  q_done[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   // Transaction-level model state
   bit         m_busy = 1'b0;
   logic [1:0] m_own  = 2'd0;
   int         m_end  = 0;
   bit         m_tmo  = 1'b0;
   int         m_free = 0;
   bit         m_rr_last = 1'b1;
   int         m_burst = 0;

   // Stimulus knobs
   int p0 = 0, p1 = 0, pc = 0;
   int lat_lo = 2, lat_hi = 2;
   bit tmo_next = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_evt(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: DUT event with nothing expected (cycle %0d)", nm, cyc);
   endtask

   // One clock: advance the model over the edge just taken, then drive the next cycle.
   task automatic step();
      bit   drop0, drop1, dropc;
      logic [1:0] w;
      grant_t g;
      done_t  d;
      drop0 = 1'b0; drop1 = 1'b0; dropc = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
         m_busy    = 1'b0;
         m_rr_last = 1'b1;
         m_burst   = 0;
         q_done.delete();
         m_free    = cyc + 1;
      end else if (m_busy && cyc == m_end) begin
         m_busy = 1'b0;
         case (m_own)
            2'd1: begin v0_as = 1'b0; drop0 = 1'b1; m_rr_last = 1'b0; end
            2'd2: begin v1_as = 1'b0; drop1 = 1'b1; m_rr_last = 1'b1; end
            default: begin cpu_as = 1'b0; dropc = 1'b1; end
         endcase
      end else if (!m_busy && cyc >= m_free) begin
         w = 2'd0;
         if (cpu_as && m_burst == BMAX) w = 2'd3;
         else if (v0_as && v1_as)       w = m_rr_last ? 2'd1 : 2'd2;
         else if (v0_as)                w = 2'd1;
         else if (v1_as)                w = 2'd2;
         else if (cpu_as)               w = 2'd3;
         if (w != 2'd0) begin
            g.cyc  = cyc + 1;
            g.own  = w;
            g.addr = (w == 2'd1) ? v0_address : (w == 2'd2) ? v1_address : cpu_address;
            g.we   = (w == 2'd3) ? cpu_we : 1'b0;
            g.dout = cpu_dout;
            q_gnt.push_back(g);
            if (w == 2'd3 || !cpu_as) m_burst = 0;
            else if (m_burst < BMAX)  m_burst++;
            m_busy = 1'b1;
            m_own  = w;
            if (w == 2'd3 && tmo_next) begin
               m_end    = cyc + TMO;
               m_tmo    = 1'b1;
               tmo_next = 1'b0;
            end else begin
               m_end = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
               m_tmo = 1'b0;
            end
            d.cyc  = m_end;
            d.kind = (w == 2'd1) ? 1 : (w == 2'd2) ? 2 : (m_tmo ? 4 : 3);
            q_done.push_back(d);
            m_free = m_end + 2;
         end
      end
      mem_ack = m_busy && !m_tmo && (m_end == cyc + 1);
      if (m_busy && $urandom_range(3, 0) == 0) begin
         v0_address  = AW'($urandom());
         v1_address  = AW'($urandom());
         cpu_address = AW'($urandom());
         cpu_dout    = 16'($urandom());
         cpu_we      = 1'($urandom());
      end
      if (!v0_as && !drop0 && int'($urandom_range(99, 0)) < p0) begin
         v0_as = 1'b1; v0_address = AW'($urandom());
      end
      if (!v1_as && !drop1 && int'($urandom_range(99, 0)) < p1) begin
         v1_as = 1'b1; v1_address = AW'($urandom());
      end
      if (!cpu_as && !dropc && int'($urandom_range(99, 0)) < pc) begin
         cpu_as = 1'b1; cpu_address = AW'($urandom());
         cpu_we = 1'($urandom()); cpu_dout = 16'($urandom());
      end
   endtask

   task automatic drain();
      p0 = 0; p1 = 0; pc = 0;
      for (int i = 0; i < 600; i++) begin
         if (!m_busy && !v0_as && !v1_as && !cpu_as && cyc >= m_free) break;
         step();
      end
      step();
      step();
   endtask

   // Monitor: compares every grant and every completion pulse against the model queues
   logic prev_as = 1'b0;
   always @(negedge clk) begin
      int cur, nd, kind;
      grant_t g;
      done_t  d;
      if (mon_en) begin
         cur = cyc + 1;
         chk("as_vs_owner", 64'(mem_as), 64'(grant_owner != 2'd0));
         if (mem_as && !prev_as) begin
            if (q_gnt.size() == 0) fail_evt("grant");
            else begin
               g = q_gnt.pop_front();
               chk("grant_cycle", 64'(cur), 64'(g.cyc));
               chk("grant_owner", 64'(grant_owner), 64'(g.own));
               chk("grant_addr", 64'(mem_address), 64'(g.addr));
               chk("grant_we", 64'(mem_we), 64'(g.we));
               if (g.own == 2'd3 && g.we) chk("grant_dout", 64'(mem_dout), 64'(g.dout));
            end
         end
         prev_as = mem_as;
         nd = int'(v0_ack) + int'(v1_ack) + int'(cpu_ack) + int'(cpu_err);
         if (nd > 1) chk("one_done_pulse", 64'(nd), 64'd1);
         if (nd != 0) begin
            kind = v0_ack ? 1 : v1_ack ? 2 : cpu_ack ? 3 : 4;
            if (q_done.size() == 0) fail_evt("done_pulse");
            else begin
               d = q_done.pop_front();
               chk("done_cycle", 64'(cur), 64'(d.cyc));
               chk("done_kind", 64'(kind), 64'(d.kind));
            end
         end
      end
   end

   initial begin
      reset = 1'b0; mem_ack = 1'b0;
      v0_as = 1'b0; v1_as = 1'b0; cpu_as = 1'b0; cpu_we = 1'b0;
      v0_address = '0; v1_address = '0; cpu_address = '0; cpu_dout = 16'd0;

      repeat (3) step();
      chk("rst_mem_as", 64'(mem_as), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_address), 64'd0);
      chk("rst_mem_dout", 64'(mem_dout), 64'd0);
      chk("rst_owner", 64'(grant_owner), 64'd0);
      chk("rst_acks", 64'({v0_ack, v1_ack, cpu_ack, cpu_err}), 64'd0);
      reset = 1'b1;
      mon_en = 1'b1;

      // ch0 alone, fixed latency
      v0_as = 1'b1; v0_address = 22'h076370;
      repeat (12) step();

      // both video channels continuously
      p0 = 100; p1 = 100; lat_lo = 0; lat_hi = 3;
      repeat (80) step();

      // video plus CPU continuously: burst of BMAX video grants then one CPU grant
      pc = 100;
      repeat (200) step();
      drain();

      // CPU write alone
      lat_lo = 2; lat_hi = 2;
      cpu_as = 1'b1; cpu_we = 1'b1; cpu_address = 22'h000100; cpu_dout = 16'h1234;
      repeat (10) step();
      drain();

      // CPU read that never gets mem_ack, then an ordinary ch0 read
      tmo_next = 1'b1;
      cpu_as = 1'b1; cpu_we = 1'b0; cpu_address = 22'h0ABCDE;
      repeat (262) step();
      v0_as = 1'b1; v0_address = 22'h001234;
      repeat (10) step();
      drain();

      // reset while ch1 owns the bus; ch0 must win right after
      lat_lo = 8; lat_hi = 8;
      v1_as = 1'b1; v1_address = 22'h3F0F0F;
      for (int i = 0; i < 20; i++) begin
         if (m_busy && m_own == 2'd2) break;
         step();
      end
      chk("ch1_owns_before_reset", 64'(grant_owner), 64'd2);
      step();
      reset = 1'b0;
      v0_as = 1'b1; v0_address = 22'h000042;
      step();
      chk("reset_drops_as", 64'(mem_as), 64'd0);
      chk("reset_owner", 64'(grant_owner), 64'd0);
      reset = 1'b1;
      lat_lo = 1; lat_hi = 3;
      repeat (30) step();
      drain();

      // randomised mixed traffic
      lat_lo = 0; lat_hi = 4;
      for (int blk = 0; blk < 8; blk++) begin
         p0 = int'($urandom_range(80, 10));
         p1 = int'($urandom_range(80, 10));
         pc = int'($urandom_range(80, 10));
         if (blk == 5) tmo_next = 1'b1;
         repeat (200) step();
      end
      tmo_next = 1'b0;
      drain();

      chk("grants_outstanding", 64'(q_gnt.size()), 64'd0);
      chk("dones_outstanding", 64'(q_done.size()), 64'd0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
